// File: rtl/kyber_pkg.sv
// Shared Kyber-style constants, coefficient type and controller state encoding
// used by both the encryptor and the decryptor.
package kyber_pkg;

  localparam int KYBER_Q     = 17;
  localparam int KYBER_N     = 4;
  localparam int KYBER_K     = 2;
  localparam int KYBER_QHALF = 9;

  localparam int COEF_W = $clog2(KYBER_Q);

  typedef logic [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DECODE,
    DONE
  } state_t;

endpackage

// File: rtl/kyber_modq.sv
// Combinational reduction of a signed 32-bit value into [0, Q-1]
// (mathematical modulo, not the truncating remainder).
module kyber_modq
  import kyber_pkg::*;
#(
  parameter int Q = KYBER_Q
) (
  input  logic signed [31:0] x,
  output coef_t              r
);

  logic signed [31:0] rem;
  logic signed [31:0] fixed;

  always_comb begin
    // % truncates toward zero, so a negative x leaves a negative remainder.
    rem   = x % Q;
    fixed = (rem < 0) ? rem + Q : rem;
    r     = coef_t'(fixed);
  end

endmodule

// File: rtl/decrypt.sv
// Decryptor: w = v - sum_k s_k*u_k in Z_Q[x]/(x^N+1), one product term per
// cycle, then each coefficient of w is decoded to one message bit.
module decrypt
  import kyber_pkg::*;
#(
  parameter int Q     = KYBER_Q,
  parameter int N     = KYBER_N,
  parameter int K     = KYBER_K,
  parameter int QHALF = KYBER_QHALF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] u_in [K][N],
  input  logic signed [31:0] v_in [N],
  input  logic signed [31:0] sk   [K][N],
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        message,
  output logic               busy
);

  localparam int TERMS = K * N * N;
  localparam int CNT_W = $clog2(TERMS);
  localparam int KW    = (K > 1) ? $clog2(K) : 1;
  localparam int NW    = (N > 1) ? $clog2(N) : 1;
  // A coefficient decodes to 1 when it rounds to Q/2 rather than to 0 or Q.
  localparam coef_t LO_C = coef_t'((QHALF + 1) / 2);
  localparam coef_t HI_C = coef_t'(Q - (QHALF + 1) / 2);

  state_t           state, state_d;
  coef_t            u_r [K][N];
  coef_t            s_r [K][N];
  coef_t            w   [N];
  coef_t            u_m [K][N];
  coef_t            s_m [K][N];
  coef_t            v_m [N];
  logic [CNT_W-1:0] cnt;
  logic             in_ready_d, busy_d, out_valid_d;
  logic             accept, mac_last;

  logic [KW-1:0]      k_idx;
  logic [NW-1:0]      i_idx, j_idx, t_idx;
  logic               wrap;
  logic signed [31:0] prod, acc_sum;
  coef_t              acc_red;
  logic [N-1:0]       bits;

  assign accept   = in_valid && in_ready;
  assign mac_last = (cnt == CNT_W'(TERMS - 1));

  for (genvar k = 0; k < K; k++) begin : g_cap_k
    for (genvar n = 0; n < N; n++) begin : g_cap_n
      kyber_modq #(.Q(Q)) u_modq_u (.x(u_in[k][n]), .r(u_m[k][n]));
      kyber_modq #(.Q(Q)) u_modq_s (.x(sk[k][n]),   .r(s_m[k][n]));
    end
  end

  for (genvar n = 0; n < N; n++) begin : g_cap_v
    kyber_modq #(.Q(Q)) u_modq_v (.x(v_in[n]), .r(v_m[n]));
  end

  // Counter order is k (outer), i, j (inner); x^N = -1 negates wrapped terms.
  always_comb begin
    k_idx   = KW'(int'(cnt) / (N * N));
    i_idx   = NW'((int'(cnt) / N) % N);
    j_idx   = NW'(int'(cnt) % N);
    wrap    = (int'(i_idx) + int'(j_idx)) >= N;
    t_idx   = NW'((int'(i_idx) + int'(j_idx)) % N);
    prod    = $signed(32'(s_r[k_idx][i_idx])) * $signed(32'(u_r[k_idx][j_idx]));
    acc_sum = $signed(32'(w[t_idx])) + (wrap ? prod : -prod);
  end

  kyber_modq #(.Q(Q)) u_modq_acc (.x(acc_sum), .r(acc_red));

  // Coefficient 0 lands in the MSB of the payload.
  always_comb begin
    bits = '0;
    for (int n = 0; n < N; n++) begin
      bits[N-1-n] = (w[n] >= LO_C) && (w[n] <= HI_C);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (accept)                 state_d = MAC;
      MAC:     if (mac_last)               state_d = DECODE;
      DECODE:                              state_d = DONE;
      DONE:    if (out_valid && out_ready) state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state == DONE) && (state_d == DONE);
  end

  // NOTE: the operand and accumulator arrays are reset explicitly so an aborted
  // run leaves no residue; sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      message   <= '0;
      cnt       <= '0;
      for (int k = 0; k < K; k++) begin
        for (int n = 0; n < N; n++) begin
          u_r[k][n] <= '0;
          s_r[k][n] <= '0;
        end
      end
      for (int n = 0; n < N; n++) w[n] <= '0;
    end else begin
      in_ready  <= in_ready_d;
      busy      <= busy_d;
      out_valid <= out_valid_d;
      if (accept) begin
        u_r <= u_m;
        s_r <= s_m;
        w   <= v_m;
        cnt <= '0;
      end else if (state == MAC) begin
        w[t_idx] <= acc_red;
        cnt      <= cnt + 1'b1;
      end
      if (state == DECODE) message <= 32'(bits);
    end
  end

endmodule

// File: doc/decrypt.md
DECRYPT -- requirements
Module: decrypt

Interface
REQ-001 Parameter Q, default 17: coefficient modulus.
REQ-002 Parameter N, default 4: coefficients per polynomial.
REQ-003 Parameter K, default 2: module rank, i.e. polynomials per vector.
REQ-004 Parameter QHALF, default 9: decode centre.
REQ-005 Port clk, input, 1: the block's single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port in_valid, input, 1: ciphertext and secret key on the inputs are valid.
REQ-008 Port in_ready, output, 1: the block can accept a new ciphertext.
REQ-009 Port u_in, input, signed 32 x [K][N]: ciphertext vector u, with u_in[k][j] the coefficient of x^j.
REQ-010 Port v_in, input, signed 32 x [N]: ciphertext polynomial v.
REQ-011 Port sk, input, signed 32 x [K][N]: secret key vector s; values may be negative.
REQ-012 Port out_valid, output, 1: message is valid.
REQ-013 Port out_ready, input, 1: the consumer accepts the message.
REQ-014 Port message, output, 32: recovered message; bits [N-1:0] carry the payload and the upper bits are 0.
REQ-015 Port busy, output, 1: high in every state except IDLE.

Function
REQ-016 The block SHALL compute w = v - sum over k of (s_k * u_k) in Z_Q[x]/(x^N+1), then decode each coefficient of w to one message bit.
REQ-017 Every input coefficient SHALL be reduced to [0,Q-1] on capture: if x<0 then ((x%Q)+Q)%Q, else x%Q.
REQ-018 For each product term s_k[i]*u_k[j], the contribution SHALL go to index (i+j) mod N, negated when i+j>=N.
REQ-019 The accumulator SHALL be held reduced to [0,Q-1] after every update; intermediate products are at most 256 and need no more than 32 bits.
REQ-020 The FSM states SHALL be IDLE, MAC, DECODE and DONE.
REQ-021 IDLE: in_ready=1; on in_valid&&in_ready the block SHALL capture the reduced u, v and s, load the accumulator w with reduced v, clear the term counter, and go to MAC.
REQ-022 MAC: in_ready=0; the block SHALL process exactly one product term per cycle, with the counter ordering k (outer), i, j (inner) over K*N*N = 32 terms, and go to DECODE after the term with counter value 31.
REQ-023 DECODE: for each index n, bit b_n SHALL be 1 iff 5 <= w[n] <= 12, i.e. round(2*w/Q) mod 2 = 1.
REQ-024 The decoded bits SHALL be registered as message[N-1-n] = b_n, matching the encryptor's coefficient order, and the FSM SHALL go to DONE.
REQ-025 DONE: out_valid=1, with message held stable while out_ready=0.
REQ-026 On out_valid&&out_ready the block SHALL return to IDLE; out_valid SHALL fall and in_ready SHALL rise at the next edge.
REQ-027 Latency SHALL be fixed: acceptance at edge t gives out_valid high after edge t+34 (32 MAC cycles plus 1 DECODE cycle, registered).
REQ-028 Inputs SHALL be ignored outside IDLE, and changes to u_in, v_in or sk after acceptance SHALL not affect the result.
REQ-029 A new input SHALL not be accepted in the cycle out_valid&&out_ready completes; the earliest next acceptance is one cycle later.

Reset
REQ-030 rst_n low SHALL asynchronously force the state to IDLE and clear the accumulator, counter, captured operands, message, out_valid and busy to 0, and set in_ready to 1 from the first edge after release.
REQ-031 Reset asserted mid-MAC or mid-DONE SHALL abort the operation, and no stale out_valid SHALL appear afterwards.

Structure
REQ-032 Q, N, K, QHALF, the FSM state enum and the coefficient typedef SHALL live in the shared kyber_pkg package, which Encrypt uses as well.
REQ-033 Signed-to-[0,Q-1] reduction SHALL be one combinational sub-module, kyber_modq, instantiated for capture and for accumulator update.

Verification
REQ-034 u=0, v=0, s=random, then handshake -> out_valid exactly 34 edges after acceptance, message=0.
REQ-035 u=0, v={9,0,9,0} (index 0 first) -> message=4'b1010 (10).
REQ-036 Negacyclic wrap: s[0][3]=1, u[0][1]=9, all other u and s coefficients 0, v=0 -> w[0]=9 -> message=8.
REQ-037 Negative inputs and decode boundaries: s[1][0]=-1, u[1][0]=4, all other u and s coefficients 0, v={1,13,12,4} -> w={5,13,12,4} -> message=10.
REQ-038 Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> message stable and in_ready=0 throughout; then out_ready=1 -> in_ready=1 on the next cycle.
REQ-039 Assert rst_n=0 at MAC cycle 10 -> all outputs 0 immediately and no out_valid afterwards; after release, a fresh REQ-035 vector yields message=10 with 34-edge latency.
